ram64_arbiter: RTL and testbench
================================

# ram64_arbiter

Two-port round-robin access controller for the shared RAM64 (64 x 16-bit, combinational read, write on rising `clk` when `ld` high). It owns the RAM's `addr`/`in`/`ld` pins, arbitrates one read or write per cycle between two requesters (CPU data port = requester 0, loader/debug port = requester 1), and returns registered read data. An optional post-reset sequencer clears every word before normal traffic is accepted.

## Interface
- `DATA_W`, 16, RAM word width
- `ADDR_W`, 6, RAM address width (depth = 2**ADDR_W = 64)
- `INIT_VALUE`, 16'h0000, word written to every location by the init sequencer
- `clk`  in  1  rising-edge clock shared with RAM64
- `rst_n`  in  1  asynchronous, active-low reset
- `req[1:0]`  in  2  per-requester transaction request, held until granted
- `we[1:0]`  in  2  per-requester 1 = write, 0 = read; valid with `req`
- `addr0`, `addr1`  in  ADDR_W  per-requester address
- `wdata0`, `wdata1`  in  DATA_W  per-requester write data
- `gnt[1:0]`  out  2  combinational, one-hot or zero; transaction accepted this cycle
- `rvalid[1:0]`  out  2  registered; read data valid for that requester
- `rdata`  out  DATA_W  registered read data, shared by both requesters, qualified by `rvalid`
- `busy`  out  1  high while init sequencer runs; no grants while high
- `ram_addr`  out  ADDR_W  to RAM64 `addr`
- `ram_in`  out  DATA_W  to RAM64 `in`
- `ram_ld`  out  1  to RAM64 `ld`
- `ram_out`  in  DATA_W  from RAM64 `out`

## Operation
- States: INIT (clear sweep), ARB (normal). Reset enters INIT when `RAM64_ARB_INIT_EN` is defined, else ARB.
- INIT: 6-bit counter `cnt` from 0; `ram_ld`=1, `ram_addr`=`cnt`, `ram_in`=`INIT_VALUE`, `busy`=1, `gnt`=0. At `cnt`==63, the next edge writes the last word, moves to ARB and wraps `cnt` to 0.
- ARB: if exactly one `req` is high, that requester is granted. If both are high, the requester not served by the most recent grant wins. Pointer `last` resets to 1, so requester 0 wins the first tie.
- `last` updates only on a cycle with a grant.
- Granted write: `ram_ld`=1, `ram_addr`/`ram_in` from the winner; the word is written at the same edge.
- Granted read: `ram_ld`=0, `ram_addr` from the winner; `ram_out` is captured into `rdata` at the edge.
- No grant: `ram_ld`=0, `ram_addr`=0, `ram_in`=0.
- `gnt` depends combinationally on `req` and state. Requesters drop or change `req` only after seeing `gnt` at an edge.
- Read-after-write to the same address in consecutive cycles returns the new data. No same-cycle hazard exists, because only one grant is issued per cycle.

## Timing
- Reset values, forced asynchronously while `rst_n` low:
  - `gnt`=0, `rvalid`=0, `rdata`=0, `ram_ld`=0, `ram_addr`=0, `ram_in`=0.
  - `busy`=1 when `RAM64_ARB_INIT_EN` is defined, else 0.
  - `cnt`=0, `last`=1.
- `ram_ld` is gated low while `rst_n` is low. No RAM write occurs during reset.
- Grant latency: 0 cycles (same cycle as `req`) when uncontended. Under contention, worst case is 1 extra cycle.
- Write completes at the granting edge.
- Read latency: `rvalid[i]` and `rdata` valid 1 cycle after the granting cycle, for exactly 1 cycle; `rdata` holds until the next read.
- Throughput: 1 transaction per cycle; back-to-back grants to the same requester are allowed when the other is idle.
- Init duration: 64 cycles after `rst_n` release; the first possible grant is in cycle 65.
- Reset asserted mid-INIT or mid-read:
  - pending `rvalid` is dropped and the sweep is abandoned;
  - after release, the sweep restarts at address 0.

## Configuration
- `RAM64_ARB_INIT_EN` defined: INIT state, counter and `INIT_VALUE` sweep are compiled in; `busy` behaves as above.
- Undefined: the INIT logic is removed, reset enters ARB directly, `busy` is tied 0, and RAM contents after reset are undefined.

## Structure
- Package `ram64_arb_pkg`:
  - `DATA_W`=16, `ADDR_W`=6, `DEPTH`=64, `NUM_REQ`=2;
  - `typedef enum logic {INIT, ARB} arb_state_e`.
- Sub-module `rr_arb2`: 2-way round-robin grant logic. Inputs `req[1:0]`, `en`, registered `last`; outputs one-hot `gnt`. Owns the `last` register.
- Top module holds the state register, init counter, RAM pin mux and the `rdata`/`rvalid` registers.

## Test plan
- Reset then release with init enabled:
  - `ram_ld`=1 for 64 cycles on addresses 0..63 with `ram_in`=0, and `busy` falls after them;
  - reads of addresses 0, 31 and 63 return 16'h0000.
- Requester 0 writes 16'hBEEF to address 5, then reads address 5 the next cycle: `gnt[0]` in both cycles; `rvalid[0]`=1 with `rdata`=16'hBEEF one cycle after the read grant.
- Both requesters hold reads (address 1 vs address 2, preloaded 16'h0011/16'h0022) for 4 cycles:
  - grants go 0,1,0,1;
  - `rdata` sequence is 16'h0011, 16'h0022, 16'h0011, 16'h0022.
- Requester 1 alone writes addresses 10..13 back-to-back: `gnt[1]` for 4 consecutive cycles; read-back of each address matches.
- Assert `rst_n` low at init `cnt`=20 and during a pending read:
  - `ram_ld` and `rvalid` drop immediately;
  - after release, the sweep restarts at `ram_addr`=0.
- Build without `RAM64_ARB_INIT_EN`: `busy`=0, and a `req[0]` write in the first cycle after release is granted immediately.

Source files
------------

// File: rtl/ram64_arb_pkg.sv
// Shared constants and state encoding for the RAM64 two-port arbiter.
package ram64_arb_pkg;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 64;
    localparam int NUM_REQ = 2;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester the previous grant did not serve.
module rr_arb2
    import ram64_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end else begin
            gnt_o = 2'b00;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
        end else begin
            last_d = last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/ram64_arbiter.sv
// Round-robin access controller for the shared RAM64 with registered read return.
// Define RAM64_ARB_INIT_EN to compile in the post-reset clear sweep.
module ram64_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
`ifdef RAM64_ARB_INIT_EN
    ,
    parameter logic [DATA_W-1:0] INIT_VALUE = 16'h0000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_in_o,
    output logic              ram_ld_o,
    input  logic [DATA_W-1:0] ram_out_i
);
    import ram64_arb_pkg::*;

    logic [NUM_REQ-1:0] gnt_s;
    logic               init_s;
    logic [1:0]         rvalid_q;
    logic [1:0]         rvalid_d;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  rdata_d;

`ifdef RAM64_ARB_INIT_EN
    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // The sweep leaves INIT on the edge that writes the last word; cnt wraps to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ARB;
                end else begin
                    state_d = INIT;
                end
            end
            ARB:     state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_s = (state_q == INIT);
`else
    assign init_s = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_i),
        .en_i  (rst_n & ~init_s),
        .gnt_o (gnt_s)
    );

    assign gnt_o  = gnt_s;
    assign busy_o = init_s;

    // RAM pin mux; rst_n gates the pins so no write can slip through during reset.
    always_comb begin
        ram_ld_o   = 1'b0;
        ram_addr_o = {ADDR_W{1'b0}};
        ram_in_o   = {DATA_W{1'b0}};
        if (!rst_n) begin
            ram_ld_o = 1'b0;
`ifdef RAM64_ARB_INIT_EN
        end else if (init_s) begin
            ram_ld_o   = 1'b1;
            ram_addr_o = cnt_q;
            ram_in_o   = INIT_VALUE;
`endif
        end else if (gnt_s[0]) begin
            ram_ld_o   = we_i[0];
            ram_addr_o = addr0_i;
            ram_in_o   = wdata0_i;
        end else if (gnt_s[1]) begin
            ram_ld_o   = we_i[1];
            ram_addr_o = addr1_i;
            ram_in_o   = wdata1_i;
        end else begin
            ram_ld_o = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = gnt_s & ~we_i;
        if (rvalid_d != 2'b00) begin
            rdata_d = ram_out_i;
        end else begin
            rdata_d = rdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 2'b00;
            rdata_q  <= {DATA_W{1'b0}};
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
endmodule

// File: tb/tb_ram64_arbiter.sv
// Randomised and directed bench for ram64_arbiter against a behavioural RAM/arbitration model.
module tb_ram64_arbiter;
`ifdef RAM64_ARB_INIT_EN
    localparam int INIT_CYC = 64;
`else
    localparam int INIT_CYC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [5:0]  addr0 = 6'd0;
    logic [5:0]  addr1 = 6'd0;
    logic [15:0] wdata0 = 16'h0000;
    logic [15:0] wdata1 = 16'h0000;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata;
    logic        busy;
    logic [5:0]  ram_addr;
    logic [15:0] ram_in;
    logic        ram_ld;
    logic [15:0] ram_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram64_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .we_i       (we),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .wdata0_i   (wdata0),
        .wdata1_i   (wdata1),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .busy_o     (busy),
        .ram_addr_o (ram_addr),
        .ram_in_o   (ram_in),
        .ram_ld_o   (ram_ld),
        .ram_out_i  (ram_out)
    );

    // The RAM64 part the arbiter drives.
    logic [15:0] ram [64];
    always @(posedge clk) if (ram_ld) ram[ram_addr] <= ram_in;
    assign ram_out = ram[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory image, last winner, pending read return.
    logic [15:0] m_mem [64];
    bit          m_known [64];
    int          m_last = 1;
    logic [1:0]  m_pend = 2'b00;
    logic [15:0] m_rdata = 16'h0000;
    bit          m_rdata_known = 1'b1;
    int          m_init_left = INIT_CYC;
    int          m_init_idx = 0;

    always @(negedge clk) begin
        int          w;
        logic [1:0]  eg;
        logic [5:0]  a;
        logic [15:0] d;
        if (!rst_n) begin
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_ld", 32'(ram_ld), 32'd0);
            chk("rst_addr", 32'(ram_addr), 32'd0);
            chk("rst_busy", 32'(busy), 32'(INIT_CYC != 0));
            m_last = 1;
            m_pend = 2'b00;
            m_rdata = 16'h0000;
            m_rdata_known = 1'b1;
            m_init_left = INIT_CYC;
            m_init_idx = 0;
        end else if (m_init_left > 0) begin
            chk("init_busy", 32'(busy), 32'd1);
            chk("init_gnt", 32'(gnt), 32'd0);
            chk("init_ld", 32'(ram_ld), 32'd1);
            chk("init_addr", 32'(ram_addr), 32'(m_init_idx));
            chk("init_in", 32'(ram_in), 32'd0);
            chk("init_rvalid", 32'(rvalid), 32'(m_pend));
            if (m_rdata_known) chk("init_rdata", 32'(rdata), 32'(m_rdata));
            m_mem[m_init_idx] = 16'h0000;
            m_known[m_init_idx] = 1'b1;
            m_init_idx++;
            m_init_left--;
            m_pend = 2'b00;
        end else begin
            w = -1;
            if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
            else if (req[0]) w = 0;
            else if (req[1]) w = 1;
            eg = (w < 0) ? 2'b00 : 2'(2'b01 << w);
            chk("gnt", 32'(gnt), 32'(eg));
            chk("busy", 32'(busy), 32'd0);
            chk("rvalid", 32'(rvalid), 32'(m_pend));
            if (m_rdata_known) chk("rdata", 32'(rdata), 32'(m_rdata));
            if (w < 0) begin
                chk("idle_ld", 32'(ram_ld), 32'd0);
                chk("idle_addr", 32'(ram_addr), 32'd0);
                chk("idle_in", 32'(ram_in), 32'd0);
                m_pend = 2'b00;
            end else begin
                a = (w == 1) ? addr1 : addr0;
                d = (w == 1) ? wdata1 : wdata0;
                chk("pin_addr", 32'(ram_addr), 32'(a));
                chk("pin_ld", 32'(ram_ld), 32'(we[w]));
                m_last = w;
                if (we[w]) begin
                    chk("pin_in", 32'(ram_in), 32'(d));
                    m_mem[a] = d;
                    m_known[a] = 1'b1;
                    m_pend = 2'b00;
                end else begin
                    m_pend = eg;
                    m_rdata = m_mem[a];
                    m_rdata_known = m_known[a];
                end
            end
        end
    end

    task automatic drive(input int i, input bit r, input bit w, input logic [5:0] a, input logic [15:0] d);
        req[i] = r;
        we[i] = w;
        if (i == 0) begin
            addr0 = a;
            wdata0 = d;
        end else begin
            addr1 = a;
            wdata1 = d;
        end
    endtask

    task automatic wait_gnt(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (gnt[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("busy_timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input int i, input bit w, input logic [5:0] a, input logic [15:0] d,
                       output logic [15:0] rd);
        bit ok;
        @(posedge clk); #1;
        drive(i, 1'b1, w, a, d);
        wait_gnt(i, ok);
        @(posedge clk); #1;
        req[i] = 1'b0;
        @(negedge clk);
        rd = rdata;
        if (!w) chk("txn_rvalid", 32'(rvalid[i]), 32'(ok));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [1:0]  gseq [4];
        logic [15:0] rseq [4];
        logic [1:0]  exp_g [4];
        logic [15:0] exp_r [4];
        logic [1:0]  g;
        bit          ok;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_r = '{16'h0011, 16'h0022, 16'h0011, 16'h0022};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle();

`ifdef RAM64_ARB_INIT_EN
        txn(0, 1'b0, 6'd0, 16'h0000, rd);
        chk("init_rd0", 32'(rd), 32'h0000);
        txn(0, 1'b0, 6'd31, 16'h0000, rd);
        chk("init_rd31", 32'(rd), 32'h0000);
        txn(0, 1'b0, 6'd63, 16'h0000, rd);
        chk("init_rd63", 32'(rd), 32'h0000);
`endif

        // write then read back in the very next cycle
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 6'd5, 16'hBEEF);
        @(negedge clk);
        chk("beef_wr_gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 6'd5, 16'h0000);
        @(negedge clk);
        chk("beef_rd_gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("beef_rvalid", 32'(rvalid[0]), 32'd1);
        chk("beef_rdata", 32'(rdata), 32'hBEEF);

        // contention: both hold reads for four cycles
        txn(0, 1'b1, 6'd1, 16'h0011, rd);
        txn(1, 1'b1, 6'd2, 16'h0022, rd);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 6'd1, 16'h0000);
        drive(1, 1'b1, 1'b0, 6'd2, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            gseq[k] = gnt;
            if (k > 0) rseq[k-1] = rdata;
        end
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        rseq[3] = rdata;
        for (int k = 0; k < 4; k++) begin
            chk("rr_gnt", 32'(gseq[k]), 32'(exp_g[k]));
            chk("rr_rdata", 32'(rseq[k]), 32'(exp_r[k]));
        end

        // requester 1 back-to-back writes to 10..13
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 6'd10, 16'hA000 | 16'd10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bb_gnt", 32'(gnt[1]), 32'd1);
            @(posedge clk); #1;
            if (k < 3) drive(1, 1'b1, 1'b1, 6'(11 + k), 16'hA000 | 16'(11 + k));
            else req[1] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            txn(1, 1'b0, 6'(10 + k), 16'h0000, rd);
            chk("bb_readback", 32'(rd), 32'(16'hA000 | 16'(10 + k)));
        end

        // random traffic, each request held until granted
        g = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (g[i] || !req[i])
                    drive(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          6'($urandom_range(0, 7)), 16'($urandom));
            end
            @(negedge clk);
            g = gnt;
        end
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);

        // reset while a read return is pending
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 6'd5, 16'h0000);
        wait_gnt(0, ok);
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("mr_pre_rvalid", 32'(rvalid[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_rvalid", 32'(rvalid), 32'd0);
        chk("mr_ld", 32'(ram_ld), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

`ifdef RAM64_ARB_INIT_EN
        @(negedge clk);
        chk("mr_restart_addr", 32'(ram_addr), 32'd0);
        // reset again when the sweep counter reaches 20
        repeat (20) @(posedge clk);
        #2;
        chk("mi_pre_addr", 32'(ram_addr), 32'd20);
        rst_n = 1'b0;
        #1;
        chk("mi_ld", 32'(ram_ld), 32'd0);
        chk("mi_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mi_restart_addr", 32'(ram_addr), 32'd0);
        chk("mi_restart_ld", 32'(ram_ld), 32'd1);
        wait_idle();
        txn(1, 1'b0, 6'd25, 16'h0000, rd);
        chk("mi_rd25", 32'(rd), 32'h0000);
`else
        @(negedge clk);
        // write presented across reset release is granted at once
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 6'd7, 16'h7777);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("imm_busy", 32'(busy), 32'd0);
        chk("imm_gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        txn(0, 1'b0, 6'd7, 16'h0000, rd);
        chk("imm_readback", 32'(rd), 32'h7777);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
